// File: rtl/filter_fir_sym_mc.sv
// Multi-channel symmetric FIR: one shared multiplier fed by a tap pre-adder,
// half coefficient set written at runtime, channels processed in turn per frame.
module filter_fir_sym_mc #(
  parameter  int BIT_WIDTH = 16,
  parameter  int BIT_FRAC  = 14,
  parameter  int LENGTH    = 21,
  parameter  int NUM_CH    = 4,
  parameter  int UINT_IO   = 0,
  localparam int HALF      = (LENGTH + 1) / 2,
  localparam int CW        = (HALF > 1) ? $clog2(HALF) : 1
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        START_FLAG,
  input  logic [NUM_CH*BIT_WIDTH-1:0] DATA_IN,
  input  logic                        COEFF_WE,
  input  logic [CW-1:0]               COEFF_ADR,
  input  logic [BIT_WIDTH-1:0]        COEFF_DATA,
  output logic [NUM_CH*BIT_WIDTH-1:0] DATA_OUT,
  output logic                        DATA_VALID,
  output logic                        FIR_RDY
);

  localparam int  CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int  TW  = $clog2(LENGTH);
  localparam int  PW  = BIT_WIDTH + 1;
  localparam int  MW  = 2 * BIT_WIDTH + 1;
  localparam int  AW  = MW + $clog2(HALF);
  localparam bit  ODD = (LENGTH % 2) == 1;

  localparam logic [BIT_WIDTH-1:0] FLIP =
    (UINT_IO != 0) ? {1'b1, {(BIT_WIDTH-1){1'b0}}} : '0;
  localparam logic signed [AW-1:0] MAXV = AW'((2 ** (BIT_WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = -(AW'(2 ** (BIT_WIDTH - 1)));

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_MAC   = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [CW-1:0]               k_q, k_d;
  logic [CHW-1:0]              ch_q, ch_d;
  logic signed [AW-1:0]        acc_q, acc_d;
  logic                        dv_q, dv_d;
  logic [NUM_CH*BIT_WIDTH-1:0] cap_q;
  logic signed [BIT_WIDTH-1:0] tap_q  [NUM_CH][LENGTH];
  logic signed [BIT_WIDTH-1:0] coef_q [HALF];
  logic [BIT_WIDTH-1:0]        out_q  [NUM_CH];

  logic                        last_k;
  logic                        coef_wr;
  logic [TW-1:0]               ia, ib;
  logic signed [BIT_WIDTH-1:0] xa, xb;
  logic signed [PW-1:0]        pre;
  logic signed [MW-1:0]        prod;

  // Floor shift back to sample scale, then clamp to the sample range.
  function automatic logic signed [BIT_WIDTH-1:0] sat_q(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = a >>> BIT_FRAC;
    if (s > MAXV)      sat_q = MAXV[BIT_WIDTH-1:0];
    else if (s < MINV) sat_q = MINV[BIT_WIDTH-1:0];
    else               sat_q = s[BIT_WIDTH-1:0];
  endfunction

  assign last_k  = (k_q == CW'(HALF - 1));
  assign coef_wr = (state_q == S_IDLE) && COEFF_WE && (32'(COEFF_ADR) < HALF);

  // Pre-adder pairs tap k with its mirror; the odd-length centre tap stands alone.
  always_comb begin
    ia   = TW'(k_q);
    ib   = TW'(LENGTH - 1) - ia;
    xa   = tap_q[ch_q][ia];
    xb   = (ODD && last_k) ? '0 : tap_q[ch_q][ib];
    pre  = $signed({xa[BIT_WIDTH-1], xa}) + $signed({xb[BIT_WIDTH-1], xb});
    prod = coef_q[k_q] * pre;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    dv_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START_FLAG) state_d = S_LOAD;
      end
      S_LOAD: begin
        acc_d   = '0;
        ch_d    = '0;
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + AW'(prod);
        if (last_k) state_d = S_STORE;
        else        k_d     = k_q + 1'b1;
      end
      default: begin
        acc_d = '0;
        k_d   = '0;
        if (ch_q == CHW'(NUM_CH - 1)) begin
          state_d = S_IDLE;
          dv_d    = 1'b1;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_MAC;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      ch_q    <= '0;
      acc_q   <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      dv_q    <= dv_d;
    end
  end

  // Sample capture, delay lines, coefficient store and output registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cap_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        out_q[c] <= '0;
        for (int i = 0; i < LENGTH; i++) tap_q[c][i] <= '0;
      end
      for (int h = 0; h < HALF; h++) coef_q[h] <= '0;
    end else begin
      if ((state_q == S_IDLE) && START_FLAG) cap_q <= DATA_IN;
      if (coef_wr) coef_q[COEFF_ADR] <= $signed(COEFF_DATA);
      if (state_q == S_LOAD) begin
        for (int c = 0; c < NUM_CH; c++) begin
          for (int i = LENGTH - 1; i > 0; i--) tap_q[c][i] <= tap_q[c][i-1];
          tap_q[c][0] <= $signed(cap_q[c*BIT_WIDTH +: BIT_WIDTH] ^ FLIP);
        end
      end
      if (state_q == S_STORE) out_q[ch_q] <= sat_q(acc_q) ^ FLIP;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign DATA_OUT[c*BIT_WIDTH +: BIT_WIDTH] = out_q[c];
  end

  assign DATA_VALID = dv_q;
  assign FIR_RDY    = (state_q == S_IDLE);

endmodule

// File: doc/filter_fir_sym_mc.md
# filter_fir_sym_mc

Multi-channel symmetric FIR filter with one time-shared multiplier and a pre-adder. Only the half coefficient set is stored and it is written at runtime. One START_FLAG processes one new sample on each of NUM_CH channels. The block sits behind the ADC/front-end decimation stage and ahead of spike detection. It replaces the single-channel half-coefficient FIR in multi-electrode builds.

## Interface
- BIT_WIDTH, 16: sample and coefficient width.
- BIT_FRAC, 14: fractional bits of the coefficients (Q format). Must be less than BIT_WIDTH.
- LENGTH, 21: filter length (taps). Odd or even, minimum 2.
- NUM_CH, 4: number of channels, minimum 1.
- UINT_IO, 0: 1 means DATA_IN/DATA_OUT are offset-binary unsigned; 0 means two's complement.
- HALF (derived, localparam): ceil(LENGTH/2). Coefficient address width CW = max(1, clog2(HALF)).

Ports:
- CLK, input, 1: clock, rising edge.
- nRST, input, 1: asynchronous, active-low reset.
- START_FLAG, input, 1: starts one frame. Sampled only while FIR_RDY=1.
- DATA_IN, input, NUM_CH*BIT_WIDTH: channel c sits at [c*BIT_WIDTH +: BIT_WIDTH]. Captured on the START cycle.
- COEFF_WE, input, 1: coefficient write strobe.
- COEFF_ADR, input, CW: coefficient index k, from 0 to HALF-1.
- COEFF_DATA, input, BIT_WIDTH: signed coefficient h[k].
- DATA_OUT, output, NUM_CH*BIT_WIDTH: registered filtered outputs, same packing as DATA_IN.
- DATA_VALID, output, 1: one-cycle pulse when all of DATA_OUT is updated.
- FIR_RDY, output, 1: high in IDLE.

## Operation
- Reset (nRST low, any time, including mid-frame) forces:
  - state to IDLE;
  - all taps, all coefficients, the accumulator and DATA_OUT to 0;
  - DATA_VALID to 0 and FIR_RDY to 1.
- Input conversion: x = {UINT_IO ^ msb, rest}. The output uses the same conversion.
- Taps: each channel has a delay line x_c[0..LENGTH-1], where x_c[0] is the newest sample.
- State machine: IDLE -> LOAD -> (MAC -> STORE) × NUM_CH -> IDLE.
  - IDLE: if START_FLAG=1, go to LOAD. Otherwise stay.
  - LOAD, 1 cycle: every channel shifts x_c[i] <= x_c[i-1] and x_c[0] <= captured input. The accumulator is cleared, ch=0, k=0.
  - MAC, HALF cycles per channel: acc <= acc + h[k] * p, where p = x_ch[k] + x_ch[LENGTH-1-k] is computed at width BIT_WIDTH+1. For odd LENGTH at k = HALF-1 (the middle tap), the second pre-adder operand is forced to 0. k increments each cycle. After k = HALF-1, go to STORE.
  - STORE, 1 cycle: DATA_OUT[ch] <= sat(acc >>> BIT_FRAC), with output conversion applied. The accumulator is cleared and k=0. If ch = NUM_CH-1, go to IDLE and pulse DATA_VALID. Otherwise ch++ and return to MAC.
- Arithmetic:
  - The product is full precision, 2*BIT_WIDTH+1 bits.
  - The accumulator is 2*BIT_WIDTH+1+clog2(HALF) bits, so it never wraps.
  - The shift is arithmetic (floor).
  - Saturation clamps to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
- Coefficient writes:
  - Accepted only in IDLE with COEFF_ADR < HALF. Writes in other states or to other addresses are ignored.
  - If COEFF_WE and START_FLAG occur in the same IDLE cycle, the write lands first, so the new coefficient is used by that frame.
- START_FLAG outside IDLE is ignored and is not queued.
- A single multiplier instance is used. Inferred `*` is the default, so a DSP slice or an array multiplier can be substituted.

## Timing
- Frame latency is F = 1 + NUM_CH*(HALF+1) cycles, counted from the START-sampling edge to the edge that raises DATA_VALID. Defaults give F = 49.
- DATA_VALID and FIR_RDY rise on the same edge. DATA_VALID stays high exactly 1 cycle.
- DATA_OUT[c] changes only on its STORE edge and holds until the next frame.
- Back-to-back operation: START_FLAG held high gives one frame every F+1 cycles (one IDLE cycle in between).
- A coefficient write takes effect on the next clock edge.

## Test plan
All scenarios use the default parameters unless stated.
- **Impulse:** write h = 0x0400×(k+1), for k = 0..10. Drive ch0 with 16384 (1.0) and then 0 over 21 frames.
  - Required: ch0 outputs h[0..10], then h[9..0].
  - Required: ch1–3 output 0.
  - Required: DATA_VALID appears exactly 49 cycles after each START.
- **Saturation:** set all h = 0x3FFF and feed every channel 32767 for 21 frames. Required: outputs reach and hold 32767. With -32768 as input, they reach and hold -32768.
- **Even length:** LENGTH=8, NUM_CH=2 (HALF=4, F=11). Write h = {16384, 0, 0, 0} and apply a step input of 1000. Required: outputs are 1000 for 7 frames, then 2000, which confirms taps 0 and 7 are paired.
- **Unsigned I/O:** UINT_IO=1, h[0]=16384, all other h = 0. Required: input 0x8000 gives output 0x8000; input 0xC000 gives 0xC000 on the same frame.
- **Busy behaviour:** during MAC, pulse START_FLAG and COEFF_WE with adr=0 and data=0. Required: no extra frame runs and h[0] is unchanged. An address of 11 while in IDLE is ignored.
- **Async reset mid-frame:** drop nRST during the STORE of ch1. Required:
  - FIR_RDY=1 and DATA_OUT=0 immediately, without waiting for a clock;
  - DATA_VALID is not asserted;
  - coefficients and taps read back as 0.
